// File: rtl/reno_rx_ack_gen_pkg.sv
// Shared constants, offset classes and width helper for the Reno receiver ACK generator.
package reno_rx_ack_gen_pkg;

  localparam int FLOW_SEQ_NUM_W   = 32;
  localparam int FLOW_WIN_SIZE    = 128;
  localparam int TX_CNT_W         = 2;
  localparam int DELACK_TICKS_DEF = 200;
  localparam int ACK_EVERY_DEF    = 2;

  typedef enum logic [1:0] {
    SEQ_OLD,
    SEQ_BEYOND,
    SEQ_INORDER,
    SEQ_OOO
  } seq_class_e;

  function automatic int clogb2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/reno_rx_ack_gen_ones_run_len.sv
// Length of the run of ones in the receive bitmap starting at bit 1 (priority encode of first zero).
module ones_run_len
  import reno_rx_ack_gen_pkg::*;
#(
  parameter int WIN   = FLOW_WIN_SIZE,
  parameter int CNT_W = clogb2(WIN) + 1
) (
  input  logic [WIN-1:1]   bits_i,
  output logic [CNT_W-1:0] run_o
);

  always_comb begin
    run_o = CNT_W'(WIN - 1);
    // Scan downward so the lowest zero wins.
    for (int i = WIN - 1; i >= 1; i--) begin
      if (!bits_i[i]) run_o = CNT_W'(i - 1);
    end
  end

endmodule

// File: rtl/reno_rx_ack_gen.sv
// Receiver-side Reno ACK generator: receive bitmap, cumulative ACK, delayed/immediate ACK timing.
//   class   | meaning (d = data_seq - rcv_next)
//   OLD     | d in upper half of sequence space, already delivered
//   BEYOND  | WIN <= d, outside the receive window
//   INORDER | d == 0, advances rcv_next over any buffered run
//   OOO     | 0 < d < WIN, buffered in the bitmap
module reno_rx_ack_gen
  import reno_rx_ack_gen_pkg::*;
#(
  parameter int               SEQ_W        = FLOW_SEQ_NUM_W,
  parameter int               WIN          = FLOW_WIN_SIZE,
  parameter int               TXID_W       = TX_CNT_W,
  parameter int               TIMER_W      = 16,
  parameter int               DELACK_TICKS = DELACK_TICKS_DEF,
  parameter int               ACK_EVERY    = ACK_EVERY_DEF,
  parameter logic [SEQ_W-1:0] INIT_SEQ     = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic [SEQ_W-1:0]  data_seq,
  input  logic [TXID_W-1:0] data_tx_id,
  output logic              ack_valid,
  input  logic              ack_ready,
  output logic [SEQ_W-1:0]  ack_cumulative,
  output logic [SEQ_W-1:0]  ack_selective,
  output logic [TXID_W-1:0] ack_sack_tx_id,
  output logic [SEQ_W-1:0]  rcv_next_out
);

  localparam int IDX_W  = clogb2(WIN);
  localparam int CNT_W  = IDX_W + 1;
  localparam int PEND_W = clogb2(ACK_EVERY + 1);

  logic [SEQ_W-1:0]   rcv_next_q, rcv_next_d;
  logic [WIN-1:0]     bitmap_q, bitmap_d;
  logic [PEND_W-1:0]  pending_q, pending_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [SEQ_W-1:0]   last_seq_q, last_seq_d;
  logic [TXID_W-1:0]  last_txid_q, last_txid_d;
  logic               ack_valid_q, ack_valid_d;
  logic [SEQ_W-1:0]   ack_cum_q, ack_cum_d;
  logic [SEQ_W-1:0]   ack_sel_q, ack_sel_d;
  logic [TXID_W-1:0]  ack_txid_q, ack_txid_d;

  logic [SEQ_W-1:0]  offset;
  seq_class_e        seq_class;
  logic [CNT_W-1:0]  run_len;
  logic [CNT_W-1:0]  shift_amt;
  logic [PEND_W-1:0] pend_inc;
  logic              slot_free, accept, expiry, data_ack, timer_ack;

  ones_run_len #(
    .WIN   (WIN),
    .CNT_W (CNT_W)
  ) u_run_len (
    .bits_i (bitmap_q[WIN-1:1]),
    .run_o  (run_len)
  );

  assign offset    = data_seq - rcv_next_q;
  assign slot_free = ~ack_valid_q | ack_ready;
  assign accept    = data_valid & slot_free;
  assign shift_amt = run_len + CNT_W'(1);
  assign pend_inc  = pending_q + PEND_W'(1);
  // Expiry covers both the decrement-to-zero cycle and a timeout held at zero by a busy slot.
  assign expiry    = (pending_q != '0) && (timer_q <= TIMER_W'(1));

  always_comb begin
    if (offset[SEQ_W-1])              seq_class = SEQ_OLD;
    else if (offset >= SEQ_W'(WIN))   seq_class = SEQ_BEYOND;
    else if (offset == '0)            seq_class = SEQ_INORDER;
    else                              seq_class = SEQ_OOO;
  end

  always_comb begin
    rcv_next_d  = rcv_next_q;
    bitmap_d    = bitmap_q;
    pending_d   = pending_q;
    timer_d     = timer_q;
    last_seq_d  = last_seq_q;
    last_txid_d = last_txid_q;
    data_ack    = 1'b0;

    if ((timer_q != '0) && (pending_q != '0)) timer_d = timer_q - TIMER_W'(1);

    if (accept) begin
      unique case (seq_class)
        SEQ_OLD, SEQ_BEYOND: data_ack = 1'b1;
        SEQ_OOO: begin
          bitmap_d = bitmap_q | (WIN'(1) << offset[IDX_W-1:0]);
          data_ack = 1'b1;
        end
        SEQ_INORDER: begin
          rcv_next_d  = rcv_next_q + SEQ_W'(run_len) + SEQ_W'(1);
          bitmap_d    = bitmap_q >> shift_amt;
          last_seq_d  = data_seq;
          last_txid_d = data_tx_id;
          if (bitmap_q != '0) begin
            data_ack = 1'b1;
          end else begin
            pending_d = pend_inc;
            if (pend_inc >= PEND_W'(ACK_EVERY)) data_ack = 1'b1;
            else if (pending_q == '0)           timer_d  = TIMER_W'(DELACK_TICKS);
          end
        end
        default: data_ack = 1'b1;
      endcase
      // A timeout coinciding with data folds into the data's ACK.
      if (expiry) data_ack = 1'b1;
    end

    timer_ack = expiry & slot_free & ~accept;

    if (data_ack | timer_ack) begin
      pending_d = '0;
      timer_d   = '0;
    end
  end

  always_comb begin
    ack_valid_d = ack_valid_q;
    ack_cum_d   = ack_cum_q;
    ack_sel_d   = ack_sel_q;
    ack_txid_d  = ack_txid_q;
    if (data_ack) begin
      ack_valid_d = 1'b1;
      ack_cum_d   = rcv_next_d;
      ack_sel_d   = data_seq;
      ack_txid_d  = data_tx_id;
    end else if (timer_ack) begin
      ack_valid_d = 1'b1;
      ack_cum_d   = rcv_next_q;
      ack_sel_d   = last_seq_q;
      ack_txid_d  = last_txid_q;
    end else if (ack_ready) begin
      ack_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rcv_next_q  <= INIT_SEQ;
      bitmap_q    <= '0;
      pending_q   <= '0;
      timer_q     <= '0;
      last_seq_q  <= '0;
      last_txid_q <= '0;
      ack_valid_q <= 1'b0;
      ack_cum_q   <= INIT_SEQ;
      ack_sel_q   <= '0;
      ack_txid_q  <= '0;
    end else begin
      rcv_next_q  <= rcv_next_d;
      bitmap_q    <= bitmap_d;
      pending_q   <= pending_d;
      timer_q     <= timer_d;
      last_seq_q  <= last_seq_d;
      last_txid_q <= last_txid_d;
      ack_valid_q <= ack_valid_d;
      ack_cum_q   <= ack_cum_d;
      ack_sel_q   <= ack_sel_d;
      ack_txid_q  <= ack_txid_d;
    end
  end

  assign data_ready     = slot_free;
  assign ack_valid      = ack_valid_q;
  assign ack_cumulative = ack_cum_q;
  assign ack_selective  = ack_sel_q;
  assign ack_sack_tx_id = ack_txid_q;
  assign rcv_next_out   = rcv_next_q;

endmodule
